// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array front end.
// Holds the feeder FSM states and the lane/drain arithmetic.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

    // Cycles for the last beat to cross the full N x N array.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage data+valid shift register for one operand lane.
// SKEW_ZERO_FILL_EN: bubbles load zero instead of holding stage-0 data.
module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [W-1:0]     data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [W-1:0]     stage0_d;

    always_comb begin
`ifdef SKEW_ZERO_FILL_EN
        stage0_d = valid_i ? data_i : '0;
`else
        stage0_d = valid_i ? data_i : data_q[0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= stage0_d;
            valid_q[0] <= valid_i;
            for (int s = 1; s < DEPTH; s++) begin
                data_q[s]  <= data_q[s-1];
                valid_q[s] <= valid_q[s-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Tile sequencer and diagonal skew for the systolic MAC array edges.
// SKEW_ZERO_FILL_EN selects zeroed bubble data inside skew_delay_line.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    parameter int K = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           clear_acc,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_a,
    input  logic [N*W-1:0] in_b,
    output logic [N*W-1:0] a_edge,
    output logic [N*W-1:0] b_edge,
    output logic [N-1:0]   edge_valid,
    output logic           busy,
    output logic           tile_done
);

    localparam int DRAIN_CYC = drain_cycles(N);
    localparam int BW        = $clog2(K + 1);
    localparam int DW        = $clog2(2 * N);

    feeder_state_t state_q, state_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          accept;

    assign accept = in_valid && (state_q == FEED);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FEED;
                    beat_cnt_d = '0;
                end
            end
            FEED: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BW'(K - 1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign clear_acc = (state_q == IDLE) && start;
    assign in_ready  = (state_q == FEED);
    assign busy      = (state_q != IDLE);
    assign tile_done = (state_q == DONE);

    // Lane i gets i+1 stages so beats leave the edge as a diagonal.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic va;
        logic vb;

        skew_delay_line #(
            .DEPTH (i + 1),
            .W     (W)
        ) u_a (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (accept),
            .data_i  (in_a[lane_lsb(i, W) +: W]),
            .valid_o (va),
            .data_o  (a_edge[lane_lsb(i, W) +: W])
        );

        skew_delay_line #(
            .DEPTH (i + 1),
            .W     (W)
        ) u_b (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (accept),
            .data_i  (in_b[lane_lsb(i, W) +: W]),
            .valid_o (vb),
            .data_o  (b_edge[lane_lsb(i, W) +: W])
        );

        assign edge_valid[i] = va & vb;
    end

endmodule
